l1ds_req_arb: RTL and testbench
===============================

// Module: l1ds_req_arb
// PURPOSE
//  Request arbiter in front of the L1 D-cache (splus) request port. Buffers and merges
//  requests from three sources into one registered request stream:
//  - Steele vector core (VEC)
//  - Gluon core (GLU)
//  - prefetch core (PF)
//  Each output request is tagged with its source so cache responses can be steered back.
// PARAMETERS
//  ADDR_W     48  request byte-address width
//  DATA_W     64  store data width
//  ID_W        4  per-source transaction id width
//  DEPTH       2  per-source input FIFO entries (power of 2, >=2)
//  STARVE_LIM 15  max cycles an eligible PF head may lose arbitration before forced grant
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous active-high reset
//  vec_valid     in   1       VEC request valid
//  vec_ready     out  1       VEC FIFO not full
//  vec_addr      in   ADDR_W  VEC address
//  vec_wdata     in   DATA_W  VEC store data
//  vec_we        in   1       VEC store (1) / load (0)
//  vec_id        in   ID_W    VEC transaction id
//  glu_*         --   --      same six signals and widths as vec_*, for GLU
//  pf_valid      in   1       PF request valid (load only; no wdata/we)
//  pf_ready      out  1       PF FIFO not full
//  pf_addr       in   ADDR_W  PF address
//  pf_id         in   ID_W    PF transaction id
//  out_valid     out  1       arbitrated request valid
//  out_ready     in   1       cache accepts request
//  out_addr      out  ADDR_W  granted address
//  out_wdata     out  DATA_W  granted store data (0 for PF)
//  out_we        out  1       granted store flag (0 for PF)
//  out_src       out  2       0=VEC 1=GLU 2=PF
//  out_id        out  ID_W    granted transaction id
//  pf_starve_cnt out  4       current PF starvation count (debug)
// BEHAVIOUR
//  Reset: all FIFOs empty, starvation counter 0, out_valid=0.
//   All out_* data = 0. vec/glu/pf_ready = 1 on the first cycle after reset.
//  Input side:
//   - x_ready = !fifo_full. Enqueue on x_valid & x_ready.
//   - x_ready does not depend on x_valid.
//  Output side:
//   - One output register. Loaded when (!out_valid | out_ready) and any FIFO head is
//     valid. Min latency input->out_valid is 2 cycles (FIFO write, then output register).
//   - out_* stay stable while out_valid & !out_ready.
//   - Transfer completes on out_valid & out_ready.
//   - Back-to-back: one request per cycle when out_ready stays 1.
//  Arbitration (evaluated only when the output register loads):
//   - Default priority is VEC > GLU > PF.
//   - If starve_cnt == STARVE_LIM and the PF head is valid, PF wins regardless of priority.
//  Starvation counter (saturates at STARVE_LIM):
//   - Increments on each load where PF head valid but not granted.
//   - Clears on a PF grant or when the PF FIFO is empty.
//  Simultaneous events:
//   - Enqueue and dequeue of the same FIFO in one cycle is legal.
//   - A full FIFO being dequeued still reports x_ready=0 in that cycle (no pass-through).
//  Same-source order is preserved. No ordering is guaranteed across sources.
//  FIFO pointers are log2(DEPTH)+1 bits and wrap naturally.
//   - full  = MSB differ, rest equal
//   - empty = pointers equal
//  Reset asserted mid-operation: buffered and in-flight requests are discarded next cycle.
//   Sources must reissue.
// TESTING
//  1 Reset, then VEC req addr=0x100 id=3 -> out_valid cycle+2, out_src=0, out_addr=0x100, out_id=3.
//  2 VEC,GLU,PF valid same cycle, out_ready=1 -> grants in order src 0,1,2 on consecutive cycles.
//  3 PF pending, VEC streaming continuously, out_ready=1 -> PF granted on 16th load
//    (starve_cnt hits 15); counter then 0.
//  4 out_ready=0 for 5 cycles with out_valid=1 -> out_* unchanged.
//    GLU FIFO fills after 2 accepts: glu_ready=0.
//  5 GLU enqueue 4 reqs ids 0..3 with stalls -> emitted in id order 0,1,2,3.
//    FIFO pointer wrap is exercised.
//  6 Assert rst while out_valid=1 and FIFOs full -> next cycle out_valid=0, all readies=1.
//    No stale request emitted.

Source files
------------

// File: rtl/l1ds_req_arb.sv
// Three-source request arbiter for the L1 D-cache request port: per-source FIFOs,
// fixed VEC > GLU > PF priority with a prefetch anti-starvation override, one output register.
module l1ds_req_arb #(
  parameter int ADDR_W     = 48,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [ADDR_W-1:0] vec_addr,
  input  logic [DATA_W-1:0] vec_wdata,
  input  logic              vec_we,
  input  logic [ID_W-1:0]   vec_id,
  input  logic              glu_valid,
  output logic              glu_ready,
  input  logic [ADDR_W-1:0] glu_addr,
  input  logic [DATA_W-1:0] glu_wdata,
  input  logic              glu_we,
  input  logic [ID_W-1:0]   glu_id,
  input  logic              pf_valid,
  output logic              pf_ready,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic [ID_W-1:0]   pf_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_we,
  output logic [1:0]        out_src,
  output logic [ID_W-1:0]   out_id,
  output logic [3:0]        pf_starve_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = ADDR_W + DATA_W + 1 + ID_W;

  logic [2:0]    in_valid_s;
  logic [EW-1:0] in_data_s [3];
  logic [EW-1:0] head_s [3];
  logic [2:0]    full_s;
  logic [2:0]    empty_s;
  logic [2:0]    grant_s;
  logic [2:0]    deq_s;
  logic [1:0]    sel_s;
  logic [EW-1:0] sel_head_s;
  logic          load_s;

  logic              out_valid_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic [DATA_W-1:0] out_wdata_r;
  logic              out_we_r;
  logic [1:0]        out_src_r;
  logic [ID_W-1:0]   out_id_r;
  logic [3:0]        starve_cnt_r;

  assign in_valid_s   = {pf_valid, glu_valid, vec_valid};
  assign in_data_s[0] = {vec_addr, vec_wdata, vec_we, vec_id};
  assign in_data_s[1] = {glu_addr, glu_wdata, glu_we, glu_id};
  // Prefetches are always loads, so their data and store flag are forced to zero.
  assign in_data_s[2] = {pf_addr, {DATA_W{1'b0}}, 1'b0, pf_id};

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          enq_s;

    assign full_s[g]  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s[g] = (wr_ptr_r == rd_ptr_r);
    assign enq_s      = in_valid_s[g] & ~full_s[g];
    assign head_s[g]  = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (enq_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (deq_s[g]) rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
      if (enq_s) mem_r[wr_ptr_r[AW-1:0]] <= in_data_s[g];
    end
  end

  assign vec_ready = ~full_s[0];
  assign glu_ready = ~full_s[1];
  assign pf_ready  = ~full_s[2];

  assign load_s = (~out_valid_r | out_ready) & ~(&empty_s);
  assign deq_s  = load_s ? grant_s : 3'b000;

  // Grant selection: starving prefetch first, then VEC > GLU > PF.
  always_comb begin
    grant_s = 3'b000;
    sel_s   = 2'd0;
    if (~empty_s[2] && (starve_cnt_r == 4'(STARVE_LIM))) begin
      grant_s = 3'b100;
      sel_s   = 2'd2;
    end else if (~empty_s[0]) begin
      grant_s = 3'b001;
      sel_s   = 2'd0;
    end else if (~empty_s[1]) begin
      grant_s = 3'b010;
      sel_s   = 2'd1;
    end else if (~empty_s[2]) begin
      grant_s = 3'b100;
      sel_s   = 2'd2;
    end else begin
      grant_s = 3'b000;
      sel_s   = 2'd0;
    end
  end

  // Head multiplexer for the granted source.
  always_comb begin
    sel_head_s = '0;
    case (sel_s)
      2'd0:    sel_head_s = head_s[0];
      2'd1:    sel_head_s = head_s[1];
      2'd2:    sel_head_s = head_s[2];
      default: sel_head_s = '0;
    endcase
  end

  // Output register: holds while stalled, reloads on free slot or completed transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= '0;
      out_wdata_r <= '0;
      out_we_r    <= 1'b0;
      out_src_r   <= 2'd0;
      out_id_r    <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      {out_addr_r, out_wdata_r, out_we_r, out_id_r} <= sel_head_s;
      out_src_r   <= sel_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Prefetch starvation counter: counts lost loads, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (empty_s[2]) begin
      starve_cnt_r <= 4'd0;
    end else if (load_s) begin
      if (grant_s[2]) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != 4'(STARVE_LIM)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end
  end

  assign out_valid     = out_valid_r;
  assign out_addr      = out_addr_r;
  assign out_wdata     = out_wdata_r;
  assign out_we        = out_we_r;
  assign out_src       = out_src_r;
  assign out_id        = out_id_r;
  assign pf_starve_cnt = starve_cnt_r;

endmodule

// File: tb/tb_l1ds_req_arb.sv
// Scoreboard bench for l1ds_req_arb: stimulus pushes expected grants in output order,
// a negedge monitor pops and compares on every accepted output transfer.
module tb_l1ds_req_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        vec_valid, vec_ready, vec_we;
  logic [47:0] vec_addr;
  logic [63:0] vec_wdata;
  logic [3:0]  vec_id;
  logic        glu_valid, glu_ready, glu_we;
  logic [47:0] glu_addr;
  logic [63:0] glu_wdata;
  logic [3:0]  glu_id;
  logic        pf_valid, pf_ready;
  logic [47:0] pf_addr;
  logic [3:0]  pf_id;
  logic        out_valid, out_ready, out_we;
  logic [47:0] out_addr;
  logic [63:0] out_wdata;
  logic [1:0]  out_src;
  logic [3:0]  out_id;
  logic [3:0]  pf_starve_cnt;

  typedef struct packed {
    logic [1:0]  src;
    logic [47:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [3:0]  id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   acc;

  always #5 clk = ~clk;

  l1ds_req_arb dut (
    .clk(clk), .rst(rst),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_addr(vec_addr),
    .vec_wdata(vec_wdata), .vec_we(vec_we), .vec_id(vec_id),
    .glu_valid(glu_valid), .glu_ready(glu_ready), .glu_addr(glu_addr),
    .glu_wdata(glu_wdata), .glu_we(glu_we), .glu_id(glu_id),
    .pf_valid(pf_valid), .pf_ready(pf_ready), .pf_addr(pf_addr), .pf_id(pf_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_wdata(out_wdata), .out_we(out_we), .out_src(out_src), .out_id(out_id),
    .pf_starve_cnt(pf_starve_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [47:0] a, input logic [63:0] d,
                      input logic w, input logic [3:0] i);
    exp_q.push_back({s, a, d, w, i});
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every accepted output transfer must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got src=%0d addr=0x%0h id=%0d expected no transfer",
                 out_src, out_addr, out_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_src",   64'(out_src),   64'(mon_e.src));
        chk("mon_addr",  64'(out_addr),  64'(mon_e.addr));
        chk("mon_wdata", out_wdata,      mon_e.wdata);
        chk("mon_we",    64'(out_we),    64'(mon_e.we));
        chk("mon_id",    64'(out_id),    64'(mon_e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    vec_valid = 1'b0; vec_addr = 48'd0; vec_wdata = 64'd0; vec_we = 1'b0; vec_id = 4'd0;
    glu_valid = 1'b0; glu_addr = 48'd0; glu_wdata = 64'd0; glu_we = 1'b0; glu_id = 4'd0;
    pf_valid = 1'b0; pf_addr = 48'd0; pf_id = 4'd0;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr",  64'(out_addr),  64'd0);
    chk("rst_out_wdata", out_wdata,      64'd0);
    chk("rst_out_id",    64'(out_id),    64'd0);
    chk("rst_out_src",   64'(out_src),   64'd0);
    chk("rst_readies",   64'({vec_ready, glu_ready, pf_ready}), 64'd7);
    chk("rst_starve",    64'(pf_starve_cnt), 64'd0);

    // Test 1: single VEC load, two-cycle latency
    vec_valid = 1'b1; vec_addr = 48'h100; vec_id = 4'd3;
    push(2'd0, 48'h100, 64'd0, 1'b0, 4'd3);
    step();
    vec_valid = 1'b0;
    chk("t1_lat1_valid", 64'(out_valid), 64'd0);
    step();
    chk("t1_lat2_valid", 64'(out_valid), 64'd1);
    chk("t1_src",  64'(out_src),  64'd0);
    chk("t1_addr", 64'(out_addr), 64'h100);
    chk("t1_id",   64'(out_id),   64'd3);
    drain();

    // Test 2: all three sources at once
    vec_valid = 1'b1; vec_addr = 48'h200; vec_id = 4'd1; vec_we = 1'b1; vec_wdata = 64'hDEAD_BEEF_0000_AAAA;
    glu_valid = 1'b1; glu_addr = 48'h300; glu_id = 4'd2; glu_we = 1'b0; glu_wdata = 64'd0;
    pf_valid  = 1'b1; pf_addr  = 48'h400; pf_id  = 4'd5;
    push(2'd0, 48'h200, 64'hDEAD_BEEF_0000_AAAA, 1'b1, 4'd1);
    push(2'd1, 48'h300, 64'd0, 1'b0, 4'd2);
    push(2'd2, 48'h400, 64'd0, 1'b0, 4'd5);
    step();
    vec_valid = 1'b0; glu_valid = 1'b0; pf_valid = 1'b0; vec_we = 1'b0; vec_wdata = 64'd0;
    step();
    chk("t2_grant0_src", 64'(out_src), 64'd0);
    chk("t2_starve1", 64'(pf_starve_cnt), 64'd1);
    step();
    chk("t2_grant1_src", 64'(out_src), 64'd1);
    chk("t2_starve2", 64'(pf_starve_cnt), 64'd2);
    step();
    chk("t2_grant2_src", 64'(out_src), 64'd2);
    chk("t2_starve_clr", 64'(pf_starve_cnt), 64'd0);
    drain();

    // Test 3: VEC stream starves PF until the 16th load
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 20; cyc++) begin
      if (cyc == 16) chk("t3_starve_sat", 64'(pf_starve_cnt), 64'd15);
      if (cyc == 17) begin
        chk("t3_pf_src",   64'(out_src),       64'd2);
        chk("t3_pf_addr",  64'(out_addr),      64'h5000);
        chk("t3_starve_0", 64'(pf_starve_cnt), 64'd0);
      end
      pf_valid = (cyc == 0);
      pf_addr = 48'h5000; pf_id = 4'd7;
      vec_valid = 1'b1; vec_addr = 48'h1000 + 48'(acc); vec_id = 4'(acc);
      if (vec_ready) begin
        if (acc == 15) push(2'd2, 48'h5000, 64'd0, 1'b0, 4'd7);
        push(2'd0, 48'h1000 + 48'(acc), 64'd0, 1'b0, 4'(acc));
        acc++;
      end
      step();
    end
    vec_valid = 1'b0; pf_valid = 1'b0;
    drain();

    // Test 4: output stall keeps out_* stable and fills the GLU FIFO
    out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 10 && acc < 3; cyc++) begin
      glu_valid = 1'b1; glu_addr = 48'h600 + 48'(acc); glu_id = 4'(acc);
      glu_we = 1'b1; glu_wdata = 64'h55 + 64'(acc);
      if (glu_ready) begin
        push(2'd1, 48'h600 + 48'(acc), 64'h55 + 64'(acc), 1'b1, 4'(acc));
        acc++;
      end
      step();
    end
    glu_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_addr",  64'(out_addr),  64'h600);
      chk("t4_hold_wdata", out_wdata,      64'h55);
      chk("t4_hold_id",    64'(out_id),    64'd0);
      chk("t4_glu_full",   64'(glu_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    glu_we = 1'b0; glu_wdata = 64'd0;
    drain();

    // Test 5: GLU ids 0..3 with input and output stalls, order preserved
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 4; cyc++) begin
      out_ready = ((cyc % 3) != 0);
      glu_valid = ((cyc % 3) != 1);
      glu_addr = 48'h700 + 48'(acc); glu_id = 4'(acc);
      if (glu_valid && glu_ready) begin
        push(2'd1, 48'h700 + 48'(acc), 64'd0, 1'b0, 4'(acc));
        acc++;
      end
      step();
    end
    glu_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Test 6: reset with full FIFOs and a stalled output discards everything
    out_ready = 1'b0;
    vec_valid = 1'b1; vec_addr = 48'h800; vec_id = 4'd9;
    glu_valid = 1'b1; glu_addr = 48'h900; glu_id = 4'd10;
    pf_valid  = 1'b1; pf_addr  = 48'hA00; pf_id  = 4'd11;
    repeat (4) step();
    chk("t6_pre_valid",   64'(out_valid), 64'd1);
    chk("t6_pre_readies", 64'({vec_ready, glu_ready, pf_ready}), 64'd0);
    rst = 1'b1;
    vec_valid = 1'b0; glu_valid = 1'b0; pf_valid = 1'b0;
    step();
    chk("t6_rst_valid",   64'(out_valid), 64'd0);
    chk("t6_rst_readies", 64'({vec_ready, glu_ready, pf_ready}), 64'd7);
    chk("t6_rst_starve",  64'(pf_starve_cnt), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_no_stale", 64'(out_valid), 64'd0);
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
